// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARITH,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] QP_ADD = 2'b01;
  localparam logic [1:0] QP_SUB = 2'b10;

  // iter must represent 0..width inclusive
  function automatic int iter_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequencer: clear, increment, and a flag
// marking the last iteration (count == WIDTH-1).
module booth_iter_counter
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [iter_w(WIDTH)-1:0]  count,
  output logic                      last
);

  localparam int CNT_W = iter_w(WIDTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier: start/done handshake,
// iteration count, and load/add/sub/shift strobes into the datapath.
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                q_bits,
  output logic                      load,
  output logic                      add_en,
  output logic                      sub_en,
  output logic                      shift_en,
  output logic                      busy,
  output logic                      done,
  output logic [iter_w(WIDTH)-1:0]  iter
);

  state_t state_q;
  state_t state_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  booth_iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (iter),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode; only the add/sub choice looks at the live Q pair.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    load     = 1'b0;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        load    = 1'b1;
        cnt_clr = 1'b1;
        state_d = abort ? IDLE : ARITH;
      end
      ARITH: begin
        add_en = (q_bits == QP_ADD);
        sub_en = (q_bits == QP_SUB);
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // abort wins over the increment so iter lands on 0
        if (abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          state_d = cnt_last ? DONE : ARITH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: behavioural Booth datapath in the loop, checked
// against plain signed multiplication and the Booth recoding rule.
module tb_booth_controller;

  localparam int WIDTH = 4;
  localparam int IW    = $clog2(WIDTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    q_bits;
  logic          load, add_en, sub_en, shift_en, busy, done;
  logic [IW-1:0] iter;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit mon_en    = 1'b0;

  logic signed [3:0] m_op = '0;
  logic signed [3:0] q_op = '0;

  // datapath: A carries one guard bit so M = -8 subtracts correctly
  logic signed [4:0] acc;
  logic signed [4:0] mr;
  logic [3:0]        qr;
  logic              q1;

  always @(posedge clk) begin
    if (load) begin
      acc <= '0;
      qr  <= q_op;
      q1  <= 1'b0;
      mr  <= {m_op[3], m_op};
    end else if (add_en) begin
      acc <= acc + mr;
    end else if (sub_en) begin
      acc <= acc - mr;
    end else if (shift_en) begin
      {acc, qr, q1} <= $signed({acc, qr, q1}) >>> 1;
    end
  end

  assign q_bits = {qr[0], q1};
  wire [7:0] prod = {acc[3:0], qr};
  wire [5:0] sv   = {load, add_en, sub_en, shift_en, done, busy};

  booth_controller #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .q_bits   (q_bits),
    .load     (load),
    .add_en   (add_en),
    .sub_en   (sub_en),
    .shift_en (shift_en),
    .busy     (busy),
    .done     (done),
    .iter     (iter)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      total_cnt++;
      if ((add_en && sub_en) || (int'(load) + int'(add_en | sub_en) + int'(shift_en) > 1) ||
          (int'(iter) > WIDTH))
        $display("FAIL strobe_excl: load=%b add=%b sub=%b shift=%b iter=%0d, required <=1 strobe and iter<=%0d",
                 load, add_en, sub_en, shift_en, iter, WIDTH);
      else pass_cnt++;
    end
  end

  task automatic run_mult(input logic signed [3:0] m, input logic signed [3:0] q,
                          input bit noise, input string tag,
                          output int n_add, output int n_sub);
    logic [7:0] exp_p;
    logic [3:0] qb;
    logic       prev;
    logic [1:0] pair;
    logic       ea, es;
    n_add = 0;
    n_sub = 0;
    m_op  = m;
    q_op  = q;
    qb    = q;
    exp_p = 8'(int'(m) * int'(q));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (sv !== 6'b100001) $display("FAIL %s_load: got %b required %b", tag, sv, 6'b100001);
    else pass_cnt++;
    prev = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      pair = {qb[i], prev};
      prev = qb[i];
      ea   = (pair == 2'b01);
      es   = (pair == 2'b10);
      @(negedge clk);
      if (noise) start = 1'($urandom_range(0, 1));
      total_cnt++;
      if (sv !== {1'b0, ea, es, 3'b001} || iter !== IW'(i))
        $display("FAIL %s_arith%0d: got %b iter=%0d required %b iter=%0d",
                 tag, i, sv, iter, {1'b0, ea, es, 3'b001}, i);
      else pass_cnt++;
      if (add_en) n_add++;
      if (sub_en) n_sub++;
      @(negedge clk);
      if (noise) start = 1'($urandom_range(0, 1));
      total_cnt++;
      if (sv !== 6'b000101 || iter !== IW'(i))
        $display("FAIL %s_shift%0d: got %b iter=%0d required %b iter=%0d",
                 tag, i, sv, iter, 6'b000101, i);
      else pass_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (sv !== 6'b000011 || iter !== IW'(WIDTH))
      $display("FAIL %s_done: got %b iter=%0d required %b iter=%0d", tag, sv, iter, 6'b000011, WIDTH);
    else pass_cnt++;
    total_cnt++;
    if (prod !== exp_p) $display("FAIL %s_product: got %h required %h", tag, prod, exp_p);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (sv !== 6'b000000) $display("FAIL %s_idle: got %b required %b", tag, sv, 6'b000000);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (sv !== 6'b000000 || iter !== '0)
        $display("FAIL reset_hold%0d: got %b iter=%0d required 000000 iter=0", i, sv, iter);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (load !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_release_load: got load=%b busy=%b required 1 1", load, busy);
    else pass_cnt++;
    repeat (2 * WIDTH + 3) @(negedge clk);
  endtask

  task automatic test_full();
    int na, ns;
    run_mult(4'sd3, -4'sd2, 1'b0, "full", na, ns);
    total_cnt++;
    if (na !== 0 || ns !== 1) $display("FAIL full_strobes: got add=%0d sub=%0d required 0 1", na, ns);
    else pass_cnt++;
  endtask

  task automatic test_extreme();
    int na, ns;
    run_mult(-4'sd8, -4'sd8, 1'b0, "neg8", na, ns);
    total_cnt++;
    if (na !== 0 || ns !== 1) $display("FAIL neg8_strobes: got add=%0d sub=%0d required 0 1", na, ns);
    else pass_cnt++;
    total_cnt++;
    if (prod !== 8'h40) $display("FAIL neg8_hold: got %h required 40", prod);
    else pass_cnt++;
    run_mult(4'sd7, 4'sd5, 1'b0, "pos", na, ns);
    total_cnt++;
    if (prod !== 8'h23) $display("FAIL pos_hold: got %h required 23", prod);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int na, ns, seen;
    m_op = 4'($urandom);
    q_op = 4'($urandom);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (shift_en !== 1'b1 || iter !== IW'(1))
      $display("FAIL abort_in_shift: got shift=%b iter=%0d required 1 1", shift_en, iter);
    else pass_cnt++;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (sv !== 6'b000000 || iter !== '0)
      $display("FAIL abort_idle: got %b iter=%0d required 000000 iter=0", sv, iter);
    else pass_cnt++;
    seen = 0;
    repeat (2 * WIDTH + 3) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_quiet: got %0d busy/done cycles required 0", seen);
    else pass_cnt++;
    run_mult(4'($urandom), 4'($urandom), 1'b0, "post_abort", na, ns);
  endtask

  task automatic test_reset_mid();
    int na, ns;
    m_op = 4'($urandom);
    q_op = 4'b0001;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (sub_en !== 1'b1) $display("FAIL rstmid_arith_sub: got %b required 1", sub_en);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (sv !== 6'b000000 || iter !== '0)
      $display("FAIL rstmid_outputs: got %b iter=%0d required 000000 iter=0", sv, iter);
    else pass_cnt++;
    run_mult(4'($urandom), 4'($urandom), 1'b0, "post_rst", na, ns);
  endtask

  task automatic test_start_ignored();
    int na, ns;
    for (int r = 0; r < 3; r++) begin
      run_mult(4'($urandom), 4'($urandom), 1'b1, "busy_start", na, ns);
      @(negedge clk);
      total_cnt++;
      if (sv !== 6'b000000) $display("FAIL busy_start_noqueue: got %b required 000000", sv);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int na, ns;
    for (int r = 0; r < 6; r++) run_mult(4'($urandom), 4'($urandom), 1'b0, "rand", na, ns);
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    m_op = 4'sd3;
    q_op = 4'sd5;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(c);
        total_cnt++;
        if (prod !== 8'd15) $display("FAIL b2b_product: got %h required 0f", prod);
        else pass_cnt++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (done_cyc.size() != 6) $display("FAIL b2b_count: got %0d dones required 6", done_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (done_cyc.size() == 0 || done_cyc[0] != 2 * WIDTH + 1)
      $display("FAIL b2b_first: got cycle %0d required %0d",
               (done_cyc.size() == 0) ? -1 : done_cyc[0], 2 * WIDTH + 1);
    else pass_cnt++;
    for (int k = 1; k < done_cyc.size(); k++) begin
      total_cnt++;
      if (done_cyc[k] - done_cyc[k-1] != 2 * WIDTH + 3)
        $display("FAIL b2b_period: got %0d required %0d", done_cyc[k] - done_cyc[k-1], 2 * WIDTH + 3);
      else pass_cnt++;
    end
    repeat (2 * WIDTH + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_full();
    test_extreme();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_random();
    test_back_to_back();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
